pit_irq_arbiter: RTL and testbench
==================================

// Module: pit_irq_arbiter
// PURPOSE
//  Shares one interrupt line between NUM_SRC timer channels (minipit instances or similar pulse sources).
//  Rising edges on irq_src are latched as pending bits.
//  Unmasked pending sources are granted round-robin and presented as irq_valid/irq_id.
//  A request is held until the consumer pulses irq_ack.
//  Sits between the timer bank and the core/JTAG-visible status logic.
// PARAMETERS
//  NUM_SRC  4  number of interrupt sources (2..16)
//  ID_W     2  width of irq_id; must equal clog2(NUM_SRC)
// PORTS
//  clk           input   1        system clock, all logic on rising edge
//  reset         input   1        synchronous, active-high reset
//  irq_src       input   NUM_SRC  raw interrupt levels/pulses from timer channels
//  irq_mask      input   NUM_SRC  1 = source masked (latched but never granted)
//  irq_ack       input   1        consumer acknowledges presented interrupt (1-cycle pulse)
//  ovf_clr       input   1        clears all overflow bits
//  irq_valid     output  1        interrupt presented to consumer
//  irq_id        output  ID_W     index of presented source (valid when irq_valid)
//  pending       output  NUM_SRC  latched, not-yet-acknowledged edges
//  overflow      output  NUM_SRC  sticky: an edge arrived while that source was already pending
// BEHAVIOUR
//  Reset (sync, active-high):
//   - irq_valid=0, irq_id=0, pending=0, overflow=0, RR pointer=0, FSM=IDLE.
//   - The edge-detect history register is loaded with all ones, so a source already high at reset release produces no edge.
//  Edge detect:
//   - rise[i] = irq_src[i] & ~src_q[i]; src_q <= irq_src every cycle.
//   - rise at cycle t sets pending[i], visible at t+1.
//   - rise[i] while pending[i]=1 sets overflow[i]; pending stays 1 (no counting).
//  FSM states:
//   - IDLE: if |(pending & ~irq_mask) -> ARB, else stay.
//   - ARB: grant the first unmasked pending index searching ptr, ptr+1, ... wrapping modulo NUM_SRC.
//     - Latch the winner into irq_id and go to PRESENT.
//     - If no candidate remains (mask changed), go back to IDLE.
//   - PRESENT: irq_valid=1, irq_id held stable. Changes to irq_mask or pending have no effect here.
//     - On irq_ack: clear pending[irq_id], set ptr = (irq_id+1) mod NUM_SRC, irq_valid=0 next cycle, go to IDLE.
//  Latency: edge at cycle t -> pending at t+1 -> ARB at t+2 -> irq_valid=1 at t+3.
//  Back-to-back: after an ack the next grant is presented 3 cycles later (IDLE, ARB, PRESENT).
//  irq_ack outside PRESENT is ignored.
//  Simultaneous ack of source i and new rise[i]:
//   - The new edge wins: pending[i] stays 1 and overflow is not set.
//   - i is re-granted after the other pending sources (RR order).
//  ovf_clr together with a new overflow event on bit i: the set wins for bit i; all other bits clear.
//  Masked pending bits remain latched and become eligible when unmasked.
//  Reset asserted in any state aborts the presented interrupt and discards all pending bits in the same cycle.
// TESTING
//  1. Pulse irq_src[2] for 1 cycle at t=10, no ack:
//     -> pending=4'b0100 at t=11, irq_valid=1 with irq_id=2 at t=13 and held until ack.
//  2. irq_src=4'b1011 rising together, ack each grant 1 cycle after irq_valid:
//     -> grant order 0,1,3; pending returns to 0.
//  3. Continuing from 2, raise src 0 and 3 again:
//     -> grant order 0,3 (ptr was 0 after granting 3, so 0 first); RR wrap checked.
//  4. Two edges on src 1 before ack -> overflow=4'b0010; ovf_clr pulse -> overflow=0, pending[1] unaffected.
//  5. irq_mask=4'b0001 with pending[0] set:
//     -> irq_valid stays 0 indefinitely; clearing the mask gives irq_valid=1, irq_id=0 two cycles after the mask change.
//  6. Assert reset while irq_valid=1 with irq_src held high:
//     -> next cycle irq_valid=0, pending=0, overflow=0.
//     -> No new grant after release until irq_src falls and rises again.

Source files
------------

// File: rtl/pit_irq_arbiter.sv
// -----------------------------------------------------------------------------
// pit_irq_arbiter
//
// Shares one interrupt line between NUM_SRC timer channels. Rising edges on
// irq_src are latched as pending bits; unmasked pending sources are granted
// round-robin and presented on irq_valid/irq_id until the consumer pulses
// irq_ack. An edge that lands on an already-pending source sets a sticky
// overflow bit.
//
// Ports
//   clk        in   1        system clock, all logic on rising edge
//   reset      in   1        synchronous, active-high reset
//   irq_src    in   NUM_SRC  raw interrupt levels/pulses from timer channels
//   irq_mask   in   NUM_SRC  1 = source masked (latched but never granted)
//   irq_ack    in   1        consumer acknowledges the presented interrupt
//   ovf_clr    in   1        clears all overflow bits
//   irq_valid  out  1        interrupt presented to consumer
//   irq_id     out  ID_W     index of presented source (valid with irq_valid)
//   pending    out  NUM_SRC  latched, not-yet-acknowledged edges
//   overflow   out  NUM_SRC  sticky: edge arrived while source already pending
//
// Parameters
//   NUM_SRC  number of interrupt sources (2..16)
//   ID_W     width of irq_id; must equal $clog2(NUM_SRC)
// -----------------------------------------------------------------------------
module pit_irq_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               irq_ack,
  input  logic               ovf_clr,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [NUM_SRC-1:0] src_q;          // previous irq_src, for edge detection
  logic [NUM_SRC-1:0] rise;           // rising edges this cycle
  logic [NUM_SRC-1:0] cand;           // grant candidates: pending and unmasked
  logic [NUM_SRC-1:0] ack_vec;        // one-hot of the source being acked
  logic               ack_hit;        // ack accepted this cycle
  logic [NUM_SRC-1:0] pending_next;
  logic [NUM_SRC-1:0] overflow_next;

  logic [ID_W-1:0]    ptr;            // round-robin search start
  logic [ID_W-1:0]    ptr_next;
  logic [ID_W-1:0]    irq_id_next;
  logic [ID_W-1:0]    win_id;
  logic               win_found;

  // Increment modulo NUM_SRC; NUM_SRC need not be a power of two.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    if (v == ID_W'(NUM_SRC - 1)) begin
      return '0;
    end
    return v + ID_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Edge detect and candidate set
  // ---------------------------------------------------------------------------
  assign rise = irq_src & ~src_q;
  assign cand = pending & ~irq_mask;

  // ---------------------------------------------------------------------------
  // Round-robin search: first candidate at ptr, ptr+1, ... wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [ID_W-1:0] idx;
    // NOTE: every variable driven here gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    win_found = 1'b0;
    win_id    = '0;
    idx       = ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
      idx = wrap_inc(idx);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state / outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    irq_id_next = irq_id;
    ptr_next    = ptr;
    ack_hit     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (|cand) begin
          state_next = ST_ARB;
        end
      end

      ST_ARB: begin
        // The mask may have changed since IDLE looked; re-check here.
        if (win_found) begin
          irq_id_next = win_id;
          state_next  = ST_PRESENT;
        end else begin
          state_next  = ST_IDLE;
        end
      end

      ST_PRESENT: begin
        // Mask and pending changes are deliberately ignored while presenting
        // so irq_id stays stable for the consumer.
        if (irq_ack) begin
          ack_hit    = 1'b1;
          ptr_next   = wrap_inc(irq_id);
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign irq_valid = (state == ST_PRESENT);

  // ---------------------------------------------------------------------------
  // Pending / overflow update
  // ---------------------------------------------------------------------------
  always_comb begin
    ack_vec = '0;
    if (ack_hit) begin
      ack_vec[irq_id] = 1'b1;
    end
  end

  // A new edge on the source being acked wins: the bit stays pending and, since
  // the old request is being retired, this is not counted as an overflow.
  assign pending_next  = (pending & ~ack_vec) | rise;

  // A new overflow event beats ovf_clr for its own bit only.
  assign overflow_next = (ovf_clr ? '0 : overflow) | (rise & pending & ~ack_vec);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state    <= ST_IDLE;
      irq_id   <= '0;
      ptr      <= '0;
      pending  <= '0;
      overflow <= '0;
      // History all ones: a source already high at release is not an edge.
      src_q    <= '1;
    end else begin
      state    <= state_next;
      irq_id   <= irq_id_next;
      ptr      <= ptr_next;
      pending  <= pending_next;
      overflow <= overflow_next;
      src_q    <= irq_src;
    end
  end

endmodule

// File: tb/tb_pit_irq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pit_irq_arbiter
//
// Directed stimulus with hand-computed expectations, plus a behavioural model
// of the arbiter compared against the DUT on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_pit_irq_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_src;
  logic [N-1:0]  irq_mask;
  logic          irq_ack;
  logic          ovf_clr;
  logic          irq_valid;
  logic [ID_W-1:0] irq_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  overflow;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  pit_irq_arbiter #(.NUM_SRC(N), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .irq_mask  (irq_mask),
    .irq_ack   (irq_ack),
    .ovf_clr   (ovf_clr),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: pending set, a grant slot, a round-robin pointer.
  // A grant is decided one cycle after candidates are seen while idle and is
  // shown from the following cycle until acknowledged.
  // ---------------------------------------------------------------------------
  bit [N-1:0] m_hist, m_pend, m_ovf;
  bit         m_valid, m_decide;
  int         m_id, m_ptr;

  always @(posedge clk) begin
    bit [N-1:0] r;
    bit [N-1:0] c;
    bit [N-1:0] clr;
    bit         found;
    if (reset) begin
      m_hist   = '1;
      m_pend   = '0;
      m_ovf    = '0;
      m_valid  = 1'b0;
      m_decide = 1'b0;
      m_id     = 0;
      m_ptr    = 0;
    end else begin
      r      = irq_src & ~m_hist;
      m_hist = irq_src;
      c      = m_pend & ~irq_mask;
      clr    = '0;
      if (m_valid) begin
        if (irq_ack) begin
          clr[m_id] = 1'b1;
          m_valid   = 1'b0;
          m_ptr     = (m_id + 1) % N;
        end
      end else if (m_decide) begin
        m_decide = 1'b0;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && c[(m_ptr + k) % N]) begin
            found   = 1'b1;
            m_id    = (m_ptr + k) % N;
            m_valid = 1'b1;
          end
        end
      end else begin
        m_decide = (c != '0);
      end
      m_ovf  = (ovf_clr ? '0 : m_ovf) | (r & m_pend & ~clr);
      m_pend = (m_pend & ~clr) | r;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("mdl_valid", irq_valid, m_valid);
      check("mdl_pending", pending, m_pend);
      check("mdl_overflow", overflow, m_ovf);
      if (m_valid) check("mdl_id", irq_id, m_id);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic wait_valid(input string name);
    int n = 0;
    while (!irq_valid && n < 20) begin
      tick();
      n++;
    end
    check(name, irq_valid, 1'b1);
  endtask

  // Wait for a grant, ack it one cycle later, return the granted id.
  task automatic take_grant(input string name, output int id);
    wait_valid(name);
    id = irq_valid ? int'(irq_id) : -1;
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  int g0, g1, g2;

  initial begin
    reset    = 1'b1;
    irq_src  = '0;
    irq_mask = '0;
    irq_ack  = 1'b0;
    ovf_clr  = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    check("rst_valid", irq_valid, 1'b0);
    check("rst_id", irq_id, 0);
    check("rst_pending", pending, 4'b0000);
    check("rst_overflow", overflow, 4'b0000);
    reset = 1'b0;
    tick();

    // 1: single pulse on src 2, no ack
    irq_src = 4'b0100;
    tick();
    irq_src = 4'b0000;
    check("t1_pending", pending, 4'b0100);
    check("t1_valid_t1", irq_valid, 1'b0);
    tick();
    check("t1_valid_t2", irq_valid, 1'b0);
    tick();
    check("t1_valid_t3", irq_valid, 1'b1);
    check("t1_id", irq_id, 2);
    repeat (3) tick();
    check("t1_hold_valid", irq_valid, 1'b1);
    check("t1_hold_id", irq_id, 2);
    reset = 1'b1;
    tick();
    check("t1_rst_valid", irq_valid, 1'b0);
    check("t1_rst_pending", pending, 4'b0000);
    reset = 1'b0;
    tick();

    // 2: sources 0,1,3 rise together
    irq_src = 4'b1011;
    tick();
    irq_src = 4'b0000;
    take_grant("t2_wait0", g0);
    take_grant("t2_wait1", g1);
    take_grant("t2_wait2", g2);
    check("t2_g0", g0, 0);
    check("t2_g1", g1, 1);
    check("t2_g2", g2, 3);
    check("t2_pending", pending, 4'b0000);

    // 3: sources 0,3 again; pointer wrapped to 0
    irq_src = 4'b1001;
    tick();
    irq_src = 4'b0000;
    take_grant("t3_wait0", g0);
    take_grant("t3_wait1", g1);
    check("t3_g0", g0, 0);
    check("t3_g1", g1, 3);
    check("t3_pending", pending, 4'b0000);

    // 4: two edges on src 1 before ack, then ovf_clr
    irq_src = 4'b0010;
    tick();
    irq_src = 4'b0000;
    tick();
    irq_src = 4'b0010;
    tick();
    irq_src = 4'b0000;
    check("t4_overflow", overflow, 4'b0010);
    check("t4_pending", pending, 4'b0010);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_clr", overflow, 4'b0000);
    check("t4_pending_kept", pending, 4'b0010);
    take_grant("t4_wait", g0);
    check("t4_g0", g0, 1);
    check("t4_pending_done", pending, 4'b0000);

    // ack of src 1 coinciding with a new edge on src 1 (ptr is 2 here)
    irq_src = 4'b1010;
    tick();
    irq_src = 4'b0000;
    take_grant("ar_wait0", g0);
    check("ar_g0", g0, 3);
    wait_valid("ar_wait1");
    check("ar_id1", irq_id, 1);
    irq_src = 4'b1000;
    tick();
    irq_src = 4'b0010;
    irq_ack = 1'b1;
    tick();
    irq_src = 4'b0000;
    irq_ack = 1'b0;
    check("ar_pending", pending, 4'b1010);
    check("ar_overflow", overflow, 4'b0000);
    take_grant("ar_wait2", g1);
    take_grant("ar_wait3", g2);
    check("ar_g1", g1, 3);
    check("ar_g2", g2, 1);

    // 5: masked source stays latched, granted two cycles after unmask
    irq_mask = 4'b0001;
    irq_src  = 4'b0001;
    tick();
    irq_src  = 4'b0000;
    repeat (8) tick();
    check("t5_masked_valid", irq_valid, 1'b0);
    check("t5_masked_pending", pending, 4'b0001);
    irq_mask = 4'b0000;
    tick();
    check("t5_unmask_c1", irq_valid, 1'b0);
    tick();
    check("t5_unmask_c2", irq_valid, 1'b1);
    check("t5_id", irq_id, 0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;

    // 6: reset while presenting, source held high
    irq_src = 4'b0001;
    wait_valid("t6_wait");
    check("t6_id", irq_id, 0);
    reset = 1'b1;
    tick();
    check("t6_rst_valid", irq_valid, 1'b0);
    check("t6_rst_pending", pending, 4'b0000);
    check("t6_rst_overflow", overflow, 4'b0000);
    reset = 1'b0;
    repeat (6) tick();
    check("t6_no_grant", irq_valid, 1'b0);
    check("t6_no_pending", pending, 4'b0000);
    irq_src = 4'b0000;
    tick();
    irq_src = 4'b0001;
    tick();
    check("t6_re_edge", pending, 4'b0001);
    take_grant("t6_wait2", g0);
    check("t6_g0", g0, 0);
    irq_src = 4'b0000;
    repeat (3) tick();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
